// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: register-address width, hazard stall lengths and the
// stall-FSM state encoding used by the ID-stage hazard logic.
package pipeline_pkg;

  localparam int unsigned REG_AW            = 5;
  localparam int unsigned LOAD_STALL        = 1;
  localparam int unsigned BR_ALU_STALL      = 1;
  localparam int unsigned BR_LOAD_EX_STALL  = 2;
  localparam int unsigned BR_LOAD_MEM_STALL = 1;
  localparam int unsigned MAX_STALL         = 3;

  typedef enum logic [0:0] {
    HS_IDLE  = 1'b0,
    HS_STALL = 1'b1
  } hs_state_e;

endpackage

// File: rtl/hazard_stall_calc.sv
// Combinational stall-length calculator: yields the number of cycles the ID stage
// must hold for load-use and branch-operand hazards (max of applicable terms).
module hazard_stall_calc #(
  parameter int unsigned REG_AW            = pipeline_pkg::REG_AW,
  parameter int unsigned LOAD_STALL        = pipeline_pkg::LOAD_STALL,
  parameter int unsigned BR_ALU_STALL      = pipeline_pkg::BR_ALU_STALL,
  parameter int unsigned BR_LOAD_EX_STALL  = pipeline_pkg::BR_LOAD_EX_STALL,
  parameter int unsigned BR_LOAD_MEM_STALL = pipeline_pkg::BR_LOAD_MEM_STALL,
  parameter int unsigned MAX_STALL         = pipeline_pkg::MAX_STALL,
  parameter int unsigned CntW              = $clog2(MAX_STALL + 1)
) (
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rs_i,
  input  logic              id_uses_rt_i,
  input  logic              id_is_branch_i,
  input  logic              ex_reg_write_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_dst_i,
  input  logic              mem_reg_write_i,
  input  logic              mem_mem_read_i,
  input  logic [REG_AW-1:0] mem_dst_i,
  output logic [CntW-1:0]   stall_n_o
);

  function automatic logic reg_match(input logic              used,
                                     input logic [REG_AW-1:0] src,
                                     input logic [REG_AW-1:0] dst,
                                     input logic              wr);
    return used && wr && (dst != '0) && (src == dst);
  endfunction

  logic ex_hit, mem_hit;
  logic ex_load_hit, ex_alu_hit, mem_load_hit;
  logic [CntW-1:0] n_max;

  assign ex_hit  = reg_match(id_uses_rs_i, id_rs_i, ex_dst_i, ex_reg_write_i) ||
                   reg_match(id_uses_rt_i, id_rt_i, ex_dst_i, ex_reg_write_i);
  assign mem_hit = reg_match(id_uses_rs_i, id_rs_i, mem_dst_i, mem_reg_write_i) ||
                   reg_match(id_uses_rt_i, id_rt_i, mem_dst_i, mem_reg_write_i);

  assign ex_load_hit  = ex_hit && ex_mem_read_i;
  assign ex_alu_hit   = ex_hit && !ex_mem_read_i;
  // A MEM non-load is covered by forwarding, so only a MEM load can stall a branch.
  assign mem_load_hit = mem_hit && mem_mem_read_i;

  always_comb begin
    n_max = '0;
    if (!id_is_branch_i && ex_load_hit && (CntW'(LOAD_STALL) > n_max)) begin
      n_max = CntW'(LOAD_STALL);
    end
    if (id_is_branch_i && ex_load_hit && (CntW'(BR_LOAD_EX_STALL) > n_max)) begin
      n_max = CntW'(BR_LOAD_EX_STALL);
    end
    if (id_is_branch_i && ex_alu_hit && (CntW'(BR_ALU_STALL) > n_max)) begin
      n_max = CntW'(BR_ALU_STALL);
    end
    if (id_is_branch_i && mem_load_hit && (CntW'(BR_LOAD_MEM_STALL) > n_max)) begin
      n_max = CntW'(BR_LOAD_MEM_STALL);
    end
  end

  assign stall_n_o = n_max;

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard stall unit: freezes PC and IF/ID for exactly the computed number of
// cycles, squashes IF/ID on taken branches and counts stall cycles (saturating).
module hazard_stall_unit #(
  parameter int unsigned REG_AW            = pipeline_pkg::REG_AW,
  parameter int unsigned LOAD_STALL        = pipeline_pkg::LOAD_STALL,
  parameter int unsigned BR_ALU_STALL      = pipeline_pkg::BR_ALU_STALL,
  parameter int unsigned BR_LOAD_EX_STALL  = pipeline_pkg::BR_LOAD_EX_STALL,
  parameter int unsigned BR_LOAD_MEM_STALL = pipeline_pkg::BR_LOAD_MEM_STALL,
  parameter int unsigned MAX_STALL         = pipeline_pkg::MAX_STALL,
  parameter int unsigned PERF_W            = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [REG_AW-1:0] IFID_Rs,
  input  logic [REG_AW-1:0] IFID_Rt,
  input  logic              IFID_UsesRs,
  input  logic              IFID_UsesRt,
  input  logic              IFID_IsBranch,
  input  logic              Branch_taken,
  input  logic              EX_RegWrite,
  input  logic              EX_MemRead,
  input  logic [REG_AW-1:0] EX_WriteRegDst,
  input  logic              MEM_RegWrite,
  input  logic              MEM_MemRead,
  input  logic [REG_AW-1:0] MEM_WriteRegDst,
  output logic              PC_Write,
  output logic              IFID_Write,
  output logic              Controller_flush,
  output logic              IFID_flush,
  output logic              Stall_active,
  output logic [PERF_W-1:0] Stall_perf
);

  localparam int unsigned CntW = $clog2(MAX_STALL + 1);

  pipeline_pkg::hs_state_e state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   stall_n;
  logic [PERF_W-1:0] perf_q, perf_d;
  logic              stall;

  hazard_stall_calc #(
    .REG_AW            (REG_AW),
    .LOAD_STALL        (LOAD_STALL),
    .BR_ALU_STALL      (BR_ALU_STALL),
    .BR_LOAD_EX_STALL  (BR_LOAD_EX_STALL),
    .BR_LOAD_MEM_STALL (BR_LOAD_MEM_STALL),
    .MAX_STALL         (MAX_STALL),
    .CntW              (CntW)
  ) u_calc (
    .id_rs_i         (IFID_Rs),
    .id_rt_i         (IFID_Rt),
    .id_uses_rs_i    (IFID_UsesRs),
    .id_uses_rt_i    (IFID_UsesRt),
    .id_is_branch_i  (IFID_IsBranch),
    .ex_reg_write_i  (EX_RegWrite),
    .ex_mem_read_i   (EX_MemRead),
    .ex_dst_i        (EX_WriteRegDst),
    .mem_reg_write_i (MEM_RegWrite),
    .mem_mem_read_i  (MEM_MemRead),
    .mem_dst_i       (MEM_WriteRegDst),
    .stall_n_o       (stall_n)
  );

  // The first stall cycle is spent in IDLE, so STALL only covers the remaining N-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      pipeline_pkg::HS_IDLE: begin
        if (stall_n > CntW'(1)) begin
          state_d = pipeline_pkg::HS_STALL;
          cnt_d   = stall_n - CntW'(2);
        end
      end
      pipeline_pkg::HS_STALL: begin
        if (cnt_q == '0) begin
          state_d = pipeline_pkg::HS_IDLE;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
    endcase
  end

  // Reset gates the outputs so an in-flight stall is dropped while Rst_n is low.
  assign stall = Rst_n && ((state_q == pipeline_pkg::HS_STALL) || (stall_n != '0));

  always_comb begin
    perf_d = perf_q;
    if (stall && (perf_q != '1)) begin
      perf_d = perf_q + PERF_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= pipeline_pkg::HS_IDLE;
      cnt_q   <= '0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perf_q  <= perf_d;
    end
  end

  assign PC_Write         = !stall;
  assign IFID_Write       = !stall;
  assign Controller_flush = stall;
  assign Stall_active     = stall;
  assign IFID_flush       = Rst_n && Branch_taken && IFID_IsBranch && !stall;
  assign Stall_perf       = perf_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: a default build and a PERF_W=4 build share
// stimulus; outputs are sampled 1ns after the falling edge.
module tb_hazard_stall_unit;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [4:0] IFID_Rs, IFID_Rt, EX_WriteRegDst, MEM_WriteRegDst;
  logic       IFID_UsesRs, IFID_UsesRt, IFID_IsBranch, Branch_taken;
  logic       EX_RegWrite, EX_MemRead, MEM_RegWrite, MEM_MemRead;

  logic        a_pcw, a_ifw, a_cfl, a_ifl, a_sta;
  logic [15:0] a_perf;
  logic        b_pcw, b_ifw, b_cfl, b_ifl, b_sta;
  logic [3:0]  b_perf;

  int n_cmp = 0;
  int n_err = 0;

  // {PC_Write, IFID_Write, Controller_flush, IFID_flush, Stall_active}
  localparam logic [4:0] OutIdle  = 5'b11000;
  localparam logic [4:0] OutStall = 5'b00101;
  localparam logic [4:0] OutFlush = 5'b11010;

  always #5 Clk = ~Clk;

  hazard_stall_unit u_dut (
    .Clk (Clk), .Rst_n (Rst_n),
    .IFID_Rs (IFID_Rs), .IFID_Rt (IFID_Rt),
    .IFID_UsesRs (IFID_UsesRs), .IFID_UsesRt (IFID_UsesRt),
    .IFID_IsBranch (IFID_IsBranch), .Branch_taken (Branch_taken),
    .EX_RegWrite (EX_RegWrite), .EX_MemRead (EX_MemRead), .EX_WriteRegDst (EX_WriteRegDst),
    .MEM_RegWrite (MEM_RegWrite), .MEM_MemRead (MEM_MemRead),
    .MEM_WriteRegDst (MEM_WriteRegDst),
    .PC_Write (a_pcw), .IFID_Write (a_ifw), .Controller_flush (a_cfl),
    .IFID_flush (a_ifl), .Stall_active (a_sta), .Stall_perf (a_perf)
  );

  hazard_stall_unit #(.PERF_W (4)) u_dut_p4 (
    .Clk (Clk), .Rst_n (Rst_n),
    .IFID_Rs (IFID_Rs), .IFID_Rt (IFID_Rt),
    .IFID_UsesRs (IFID_UsesRs), .IFID_UsesRt (IFID_UsesRt),
    .IFID_IsBranch (IFID_IsBranch), .Branch_taken (Branch_taken),
    .EX_RegWrite (EX_RegWrite), .EX_MemRead (EX_MemRead), .EX_WriteRegDst (EX_WriteRegDst),
    .MEM_RegWrite (MEM_RegWrite), .MEM_MemRead (MEM_MemRead),
    .MEM_WriteRegDst (MEM_WriteRegDst),
    .PC_Write (b_pcw), .IFID_Write (b_ifw), .Controller_flush (b_cfl),
    .IFID_flush (b_ifl), .Stall_active (b_sta), .Stall_perf (b_perf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [4:0] exp);
    check(tag, {27'd0, a_pcw, a_ifw, a_cfl, a_ifl, a_sta}, {27'd0, exp});
    check({tag, ".p4"}, {27'd0, b_pcw, b_ifw, b_cfl, b_ifl, b_sta}, {27'd0, exp});
  endtask

  task automatic check_perf(input string tag, input int exp16, input int exp4);
    check(tag, {16'd0, a_perf}, exp16);
    check({tag, ".p4"}, {28'd0, b_perf}, exp4);
  endtask

  task automatic clear_inputs();
    IFID_Rs = '0; IFID_Rt = '0; IFID_UsesRs = 1'b0; IFID_UsesRt = 1'b0;
    IFID_IsBranch = 1'b0; Branch_taken = 1'b0;
    EX_RegWrite = 1'b0; EX_MemRead = 1'b0; EX_WriteRegDst = '0;
    MEM_RegWrite = 1'b0; MEM_MemRead = 1'b0; MEM_WriteRegDst = '0;
  endtask

  // Advance one clock; returns just after the falling edge, ready to drive.
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    Rst_n = 1'b0;
    step();
    Rst_n = 1'b1;
    #1;
  endtask

  task automatic ex_load(input logic [4:0] dst);
    EX_RegWrite = 1'b1; EX_MemRead = 1'b1; EX_WriteRegDst = dst;
  endtask

  initial begin
    clear_inputs();
    Rst_n = 1'b0;
    @(negedge Clk);
    #1;
    check_outs("reset_outs", OutIdle);
    check_perf("reset_perf", 0, 0);
    // Hazard present while in reset: outputs must stay forced idle.
    ex_load(5'd8); IFID_Rs = 5'd8; IFID_UsesRs = 1'b1;
    #1;
    check_outs("reset_forces_idle", OutIdle);
    do_reset();

    // lw $8 in EX, add using rs=$8 in ID: one stall cycle.
    ex_load(5'd8); IFID_Rs = 5'd8; IFID_UsesRs = 1'b1;
    #1; check_outs("ld_use_c0", OutStall);
    step(); clear_inputs();
    #1; check_outs("ld_use_after", OutIdle);
    check_perf("ld_use_perf", 1, 1);

    // Load in EX but ID does not read that register: no stall.
    do_reset();
    ex_load(5'd8); IFID_Rs = 5'd8; IFID_UsesRs = 1'b0;
    #1; check_outs("ld_unused_src", OutIdle);

    // lw $8 in EX, beq with rt=$8: two stall cycles, second one ignores inputs.
    do_reset();
    ex_load(5'd8); IFID_Rt = 5'd8; IFID_UsesRt = 1'b1; IFID_IsBranch = 1'b1;
    #1; check_outs("br_ldex_c0", OutStall);
    step(); clear_inputs();
    #1; check_outs("br_ldex_c1", OutStall);
    step();
    #1; check_outs("br_ldex_done", OutIdle);
    check_perf("br_ldex_perf", 2, 2);

    // EX writes $0 and ID reads $0: never a hazard.
    do_reset();
    EX_RegWrite = 1'b1; EX_MemRead = 1'b1; EX_WriteRegDst = 5'd0;
    IFID_UsesRs = 1'b1; IFID_UsesRt = 1'b1; IFID_IsBranch = 1'b1;
    #1; check_outs("zero_reg", OutIdle);
    step();
    #1; check_perf("zero_reg_perf", 0, 0);

    // Taken branch without hazard: flush for that cycle only.
    clear_inputs();
    IFID_IsBranch = 1'b1; Branch_taken = 1'b1; IFID_Rs = 5'd3; IFID_UsesRs = 1'b1;
    #1; check_outs("br_taken_flush", OutFlush);
    step(); clear_inputs();
    #1; check_outs("br_taken_next", OutIdle);

    // Taken branch with EX load hazard: stall wins, no flush.
    IFID_IsBranch = 1'b1; Branch_taken = 1'b1; IFID_Rs = 5'd3; IFID_UsesRs = 1'b1;
    ex_load(5'd3);
    #1; check_outs("br_taken_stall", OutStall);
    step();
    #1; check_outs("br_taken_stall_c1", OutStall);
    step(); clear_inputs();
    #1; check_outs("br_taken_stall_done", OutIdle);

    // EX ALU writes branch operand: one stall cycle.
    do_reset();
    EX_RegWrite = 1'b1; EX_WriteRegDst = 5'd4;
    IFID_IsBranch = 1'b1; IFID_Rs = 5'd4; IFID_UsesRs = 1'b1;
    #1; check_outs("br_alu_c0", OutStall);
    step(); clear_inputs();
    #1; check_outs("br_alu_done", OutIdle);
    check_perf("br_alu_perf", 1, 1);

    // MEM non-load feeding a branch is forwarded: no stall.
    MEM_RegWrite = 1'b1; MEM_WriteRegDst = 5'd7;
    IFID_IsBranch = 1'b1; IFID_Rt = 5'd7; IFID_UsesRt = 1'b1;
    #1; check_outs("br_mem_alu", OutIdle);

    // EX lw $5 and MEM lw $6 with beq $5,$6: max(2,1)=2 stall cycles, not 3.
    do_reset();
    ex_load(5'd5);
    MEM_RegWrite = 1'b1; MEM_MemRead = 1'b1; MEM_WriteRegDst = 5'd6;
    IFID_IsBranch = 1'b1; IFID_Rs = 5'd5; IFID_Rt = 5'd6;
    IFID_UsesRs = 1'b1; IFID_UsesRt = 1'b1;
    #1; check_outs("max_c0", OutStall);
    step();
    #1; check_outs("max_c1", OutStall);
    step(); clear_inputs();
    #1; check_outs("max_c2_idle", OutIdle);
    check_perf("max_perf", 2, 2);

    // Reset during the second cycle of a 2-cycle stall aborts it at once.
    do_reset();
    ex_load(5'd9); IFID_Rs = 5'd9; IFID_UsesRs = 1'b1; IFID_IsBranch = 1'b1;
    #1; check_outs("rst_mid_c0", OutStall);
    step(); clear_inputs();
    #1; check_outs("rst_mid_c1", OutStall);
    Rst_n = 1'b0;
    #1; check_outs("rst_mid_abort", OutIdle);
    step();
    Rst_n = 1'b1;
    #1; check_outs("rst_mid_release", OutIdle);
    check_perf("rst_mid_perf", 0, 0);

    // Continuous 1-cycle stalls: 4-bit counter saturates at 15.
    do_reset();
    ex_load(5'd8); IFID_Rs = 5'd8; IFID_UsesRs = 1'b1;
    repeat (15) step();
    #1; check_perf("sat_15", 15, 15);
    check_outs("sat_still_stalling", OutStall);
    repeat (6) step();
    clear_inputs();
    #1; check_perf("sat_21", 21, 15);
    check_outs("sat_done", OutIdle);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Parametrised, sequential successor to the combinational hazard detector in the ID stage of the 5-stage MIPS pipeline.
- Detects load-use hazards and branch-operand hazards for branches resolved in ID.
- Computes the required number of stall cycles and holds PC/IF-ID frozen for exactly that many cycles using a counter FSM.
- Also drives the IF-ID flush for taken branches and keeps a saturating stall-cycle performance counter.

Parameters:
- REG_AW, 5, register-address width
- LOAD_STALL, 1, stall cycles for ALU/store use of a register loaded by the instruction in EX
- BR_ALU_STALL, 1, stall cycles for a branch in ID whose operand is written by a non-load in EX
- BR_LOAD_EX_STALL, 2, stall cycles for a branch in ID whose operand is loaded by the instruction in EX
- BR_LOAD_MEM_STALL, 1, stall cycles for a branch in ID whose operand is loaded by the instruction in MEM
- MAX_STALL, 3, upper bound on any stall value; must be >= every value above
- PERF_W, 16, width of the stall performance counter

Ports:
- Clk  in  1  clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- IFID_Rs  in  REG_AW  rs field of the instruction in ID
- IFID_Rt  in  REG_AW  rt field of the instruction in ID
- IFID_UsesRs  in  1  ID instruction reads rs
- IFID_UsesRt  in  1  ID instruction reads rt
- IFID_IsBranch  in  1  ID instruction is a beq/bne-class branch
- Branch_taken  in  1  ID branch-resolution result
- EX_RegWrite  in  1  EX instruction writes the register file
- EX_MemRead  in  1  EX instruction is a load
- EX_WriteRegDst  in  REG_AW  destination register of the EX instruction
- MEM_RegWrite  in  1  MEM instruction writes the register file
- MEM_MemRead  in  1  MEM instruction is a load
- MEM_WriteRegDst  in  REG_AW  destination register of the MEM instruction
- PC_Write  out  1  0 = hold PC
- IFID_Write  out  1  0 = hold IF/ID register
- Controller_flush  out  1  1 = insert a bubble into ID/EX
- IFID_flush  out  1  1 = squash IF/ID (taken branch)
- Stall_active  out  1  high in every stall cycle
- Stall_perf  out  PERF_W  saturating count of stall cycles since reset

Behaviour:
- Match rule: a source register X matches destination D iff X is used, D != 0, the stage's RegWrite is set, and X == D.
- Required stall N is the maximum of each applicable term (0 if none):
  - LOAD_STALL when the EX load matches and the ID instruction is not a branch
  - BR_LOAD_EX_STALL when the ID instruction is a branch and the EX load matches
  - BR_ALU_STALL when the ID instruction is a branch and an EX non-load matches
  - BR_LOAD_MEM_STALL when the ID instruction is a branch and the MEM load matches
- FSM has two states, IDLE and STALL. Counter width is clog2(MAX_STALL+1).
- IDLE:
  - If N > 0, the stall outputs assert combinationally in this cycle: PC_Write=0, IFID_Write=0, Controller_flush=1, Stall_active=1.
  - If N > 1, the next state is STALL with cnt=N-2; otherwise the FSM stays in IDLE.
- STALL:
  - Stall outputs are asserted regardless of the inputs; new detections are ignored.
  - If cnt == 0, the next state is IDLE; otherwise cnt decrements.
- Total stall cycles equal N exactly. The hazard is re-evaluated in the first IDLE cycle after the stall.
- IFID_flush = Branch_taken AND IFID_IsBranch AND NOT Stall_active. A stall always wins over a taken branch, because branch operands are stale while stalled.
- Stall_perf increments by 1 on every clock edge where Stall_active=1 and saturates at all-ones.
- Reset:
  - Rst_n low asynchronously forces state=IDLE, cnt=0, Stall_perf=0.
  - While Rst_n is low, outputs are forced to PC_Write=1, IFID_Write=1, Controller_flush=0, IFID_flush=0, Stall_active=0.
  - Reset asserted mid-stall aborts the stall immediately.
- Simultaneous EX and MEM matches take the max rule, never the sum.

Decomposition:
- Shared package pipeline_pkg holds:
  - the REG_AW default
  - the stall constants (LOAD_STALL, BR_ALU_STALL, BR_LOAD_EX_STALL, BR_LOAD_MEM_STALL, MAX_STALL)
  - the FSM state encodings HS_IDLE and HS_STALL
- One natural sub-module: hazard_stall_calc, purely combinational, producing N from the register and control inputs. The FSM, counter and perf counter stay in hazard_stall_unit.

Test Plan:
- EX lw $8, ID add uses rs=$8 -> exactly 1 cycle with PC_Write=0, Controller_flush=1; Stall_perf=1.
- EX lw $8, ID beq rt=$8 -> stall for 2 consecutive cycles (IDLE then STALL), then IDLE; Stall_perf=2.
- EX add writes $0, ID uses $0 -> no stall; all outputs at idle values.
- Branch_taken=1 with ID beq and no hazard -> IFID_flush=1 for that cycle only. Same stimulus combined with an EX lw hazard -> IFID_flush=0, stall asserted.
- EX lw $5 (BR_LOAD_EX_STALL=2) and MEM lw $6 (BR_LOAD_MEM_STALL=1), ID beq $5,$6 -> 2 stall cycles, not 3.
- Drop Rst_n during the second cycle of a 2-cycle stall -> outputs return to idle values immediately; Stall_perf=0 after release.
- Force 2^PERF_W+5 stall cycles (PERF_W=4 build) -> Stall_perf saturates at 15.
